wb_slave_mem: RTL and testbench

Synchronous Wishbone slave memory that terminates cycles issued by the testbench Wishbone master model. It sits directly downstream of the master, consumes its `adr`/`dout`/`cyc`/`stb`/`sel`/`we` and returns `din`/`ack`/`err`/`rty`/`eod`. It provides programmable wait states, byte-lane writes, and address-range error detection. An optional compiled-in retry injector exercises the master's termination handling.

---
 rtl/wb_slave_mem_if.sv | 40 ++++
 rtl/wb_slave_mem.sv | 206 ++++++++++++++++++++
 tb/tb_wb_slave_mem.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_mem_if.sv
// wb_slave_mem_if
//   Wishbone bus bundle between a master model and wb_slave_mem.
//   Signals:
//     adr   byte address          (master -> slave)
//     wdat  write data            (master -> slave)
//     cyc   bus cycle             (master -> slave)
//     stb   strobe                (master -> slave)
//     sel   byte-lane enables     (master -> slave)
//     we    1 = write             (master -> slave)
//     rdat  read data             (slave -> master)
//     ack   normal termination    (slave -> master)
//     err   error termination     (slave -> master)
//     rty   retry termination     (slave -> master)
//     eod   last memory word hit  (slave -> master)
interface wb_slave_mem_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic [AWIDTH-1:0]   adr;
  logic [DWIDTH-1:0]   wdat;
  logic [DWIDTH-1:0]   rdat;
  logic                cyc;
  logic                stb;
  logic [DWIDTH/8-1:0] sel;
  logic                we;
  logic                ack;
  logic                err;
  logic                rty;
  logic                eod;

  modport master (
    output adr, wdat, cyc, stb, sel, we,
    input  rdat, ack, err, rty, eod
  );

  modport slave (
    input  adr, wdat, cyc, stb, sel, we,
    output rdat, ack, err, rty, eod
  );
endinterface

// File: rtl/wb_slave_mem.sv
// wb_slave_mem
//   Wishbone slave memory with programmable wait states, byte-lane writes
//   and address-range error termination.
//   Optional feature macro: WB_SLAVE_RTY_EN -- when defined, every
//   RTY_PERIOD-th in-range request is terminated with rty instead of ack.
//   Ports:
//     clk      clock, rising edge
//     rst      synchronous active-high reset
//     bus      wb_slave_mem_if.slave (adr/wdat/cyc/stb/sel/we in,
//              rdat/ack/err/rty/eod out)
//     acc_cnt  count of ack terminations, wraps at 16 bits
//
//   state  | meaning
//   IDLE   | waiting for cyc&stb; request fields latched on accept
//   WAIT   | counting wait states; cyc low aborts silently
//   RESP   | one termination (ack/err/rty) high; write lands on exit
module wb_slave_mem #(
  parameter int              DWIDTH      = 32,
  parameter int              AWIDTH      = 32,
  parameter int              MEMWORDS    = 1024,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
  parameter int              WAIT_STATES = 1,
  parameter int              RTY_PERIOD  = 4
) (
  input  logic                clk,
  input  logic                rst,
  wb_slave_mem_if.slave       bus,
  output logic [15:0]         acc_cnt
);

  localparam int SELW = DWIDTH / 8;
  localparam int LSB  = $clog2(SELW);
  localparam int IDXW = $clog2(MEMWORDS);
  localparam logic [AWIDTH-1:0] WORDS_A   = AWIDTH'(MEMWORDS);
  localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(MEMWORDS - 1);
  localparam logic [3:0]        WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_enter_resp;

  logic [3:0]          r_wait_cnt;
  logic [AWIDTH-1:0]   r_adr;
  logic [DWIDTH-1:0]   r_wdat;
  logic [SELW-1:0]     r_sel;
  logic                r_we;

  logic                r_ack;
  logic                r_err;
  logic                r_rty;
  logic                r_eod;
  logic [DWIDTH-1:0]   r_rdat;
  logic [15:0]         r_acc_cnt;

  logic [DWIDTH-1:0]   r_mem [MEMWORDS];

  // With zero wait states the response is decided on the accepting edge,
  // before the request registers hold anything, so look at the bus directly.
  logic [AWIDTH-1:0]   w_adr;
  logic                w_we;
  logic [AWIDTH-1:0]   w_off;
  logic [AWIDTH-1:0]   w_word;
  logic                w_in_range;
  logic [IDXW-1:0]     w_idx;
  logic                w_rty_fire;
  logic                w_do_ack;

  assign w_adr      = (r_state == S_IDLE) ? bus.adr : r_adr;
  assign w_we       = (r_state == S_IDLE) ? bus.we  : r_we;
  assign w_off      = w_adr - BASE_ADDR;
  assign w_word     = w_off >> LSB;
  assign w_in_range = (w_adr >= BASE_ADDR) && (w_word < WORDS_A);
  assign w_idx      = w_word[IDXW-1:0];
  assign w_do_ack   = w_in_range && !w_rty_fire;

`ifdef WB_SLAVE_RTY_EN
  logic [15:0] r_rty_cnt;
  logic [15:0] w_rty_cnt_inc;

  assign w_rty_cnt_inc = r_rty_cnt + 16'd1;
  assign w_rty_fire    = (RTY_PERIOD != 0) && (w_rty_cnt_inc == 16'(RTY_PERIOD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rty_cnt <= 16'd0;
    end else if (w_enter_resp && w_in_range) begin
      r_rty_cnt <= w_rty_fire ? 16'd0 : w_rty_cnt_inc;
    end
  end
`else
  assign w_rty_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cyc && bus.stb) begin
          w_accept = 1'b1;
          if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Abort wins over the final wait cycle: a dropped cycle never terminates.
        if (!bus.cyc) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == 4'd0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_adr      <= '0;
      r_wdat     <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rty      <= 1'b0;
      r_eod      <= 1'b0;
      r_rdat     <= '0;
      r_acc_cnt  <= 16'd0;
    end else begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rty  <= 1'b0;
      r_eod  <= 1'b0;
      r_rdat <= '0;

      if (w_accept) begin
        r_adr      <= bus.adr;
        r_wdat     <= bus.wdat;
        r_sel      <= bus.sel;
        r_we       <= bus.we;
        r_wait_cnt <= WAIT_INIT;
      end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end

      if (w_enter_resp) begin
        r_err <= !w_in_range;
        r_rty <= w_in_range && w_rty_fire;
        r_ack <= w_do_ack;
        r_eod <= w_do_ack && (w_idx == LAST_IDX);
        if (w_do_ack && !w_we) begin
          r_rdat <= r_mem[w_idx];
        end
        if (w_do_ack) begin
          r_acc_cnt <= r_acc_cnt + 16'd1;
        end
      end
    end
  end

  // Memory is not reset; a reset edge only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_RESP && r_ack && r_we) begin
      for (int i = 0; i < SELW; i++) begin
        if (r_sel[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdat[8*i +: 8];
        end
      end
    end
  end

  assign bus.rdat = r_rdat;
  assign bus.ack  = r_ack;
  assign bus.err  = r_err;
  assign bus.rty  = r_rty;
  assign bus.eod  = r_eod;
  assign acc_cnt  = r_acc_cnt;

endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem
//   Directed bench for wb_slave_mem. Three instances share one master
//   driver: dut1 (1 wait state), dut3 (3 wait states), dutr (1 wait state,
//   RTY_PERIOD=4). Only the selected instance sees cyc/stb.
module tb_wb_slave_mem;

  logic        clk;
  logic        rst;
  logic [31:0] m_adr;
  logic [31:0] m_wdat;
  logic [3:0]  m_sel;
  logic        m_we;
  logic        m_cyc;
  logic        m_stb;
  int          m_dut;

  logic [15:0] acc1, acc3, accr;

  int n_checks = 0;
  int n_errors = 0;

  wb_slave_mem_if #(.DWIDTH(32), .AWIDTH(32)) bus1 ();
  wb_slave_mem_if #(.DWIDTH(32), .AWIDTH(32)) bus3 ();
  wb_slave_mem_if #(.DWIDTH(32), .AWIDTH(32)) busr ();

  assign bus1.adr = m_adr;  assign bus1.wdat = m_wdat; assign bus1.sel = m_sel; assign bus1.we = m_we;
  assign bus1.cyc = m_cyc && (m_dut == 1);
  assign bus1.stb = m_stb && (m_dut == 1);
  assign bus3.adr = m_adr;  assign bus3.wdat = m_wdat; assign bus3.sel = m_sel; assign bus3.we = m_we;
  assign bus3.cyc = m_cyc && (m_dut == 3);
  assign bus3.stb = m_stb && (m_dut == 3);
  assign busr.adr = m_adr;  assign busr.wdat = m_wdat; assign busr.sel = m_sel; assign busr.we = m_we;
  assign busr.cyc = m_cyc && (m_dut == 4);
  assign busr.stb = m_stb && (m_dut == 4);

  wb_slave_mem #(.WAIT_STATES(1), .RTY_PERIOD(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .acc_cnt(acc1));
  wb_slave_mem #(.WAIT_STATES(3), .RTY_PERIOD(0)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .acc_cnt(acc3));
  wb_slave_mem #(.WAIT_STATES(1), .RTY_PERIOD(4)) dutr (.clk(clk), .rst(rst), .bus(busr), .acc_cnt(accr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int d, output logic [31:0] rd, output logic [2:0] term, output logic eod);
    case (d)
      1:       begin rd = bus1.rdat; term = {bus1.ack, bus1.err, bus1.rty}; eod = bus1.eod; end
      3:       begin rd = bus3.rdat; term = {bus3.ack, bus3.err, bus3.rty}; eod = bus3.eod; end
      default: begin rd = busr.rdat; term = {busr.ack, busr.err, busr.rty}; eod = busr.eod; end
    endcase
  endtask

  // Called at a falling edge; returns at a falling edge. term = {ack,err,rty}.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output logic [2:0] term,
                      output logic eod, output int lat);
    logic [31:0] rd2;
    logic [2:0]  term2;
    logic        eod2;
    m_dut = d; m_adr = a; m_we = w; m_sel = s; m_wdat = wd;
    m_cyc = 1'b1; m_stb = 1'b1;
    lat = 0; term = 3'b000; rd = '0; eod = 1'b0;
    while (term == 3'b000 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      sample(d, rd, term, eod);
    end
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    @(posedge clk); #1;
    sample(d, rd2, term2, eod2);
    check("term_one_cycle", {29'd0, term2}, 64'd0);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [2:0]  term;
  logic        eod;
  int          lat;
  logic [2:0]  seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_adr = '0; m_wdat = '0; m_sel = '0; m_we = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_dut = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack1",  {63'd0, bus1.ack}, 64'd0);
    check("rst_rdat1", {32'd0, bus1.rdat}, 64'd0);
    check("rst_acc1",  {48'd0, acc1}, 64'd0);
    check("rst_termr", {61'd0, busr.ack, busr.err, busr.rty}, 64'd0);
    check("rst_eod3",  {63'd0, bus3.eod}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full write then read, one wait state
    xfer(1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, rd, term, eod, lat);
    check("w10_term", {61'd0, term}, 64'b100);
    check("w10_lat",  64'(lat), 64'd2);
    xfer(1, 32'h10, 1'b0, 4'hF, 32'h0, rd, term, eod, lat);
    check("r10_term", {61'd0, term}, 64'b100);
    check("r10_lat",  64'(lat), 64'd2);
    check("r10_data", {32'd0, rd}, 64'hDEADBEEF);
    check("acc_2",    {48'd0, acc1}, 64'd2);

    // Byte-lane merge
    xfer(1, 32'h20, 1'b1, 4'hF, 32'h11223344, rd, term, eod, lat);
    xfer(1, 32'h20, 1'b1, 4'h5, 32'hAABBCCDD, rd, term, eod, lat);
    check("w20_sel5_term", {61'd0, term}, 64'b100);
    xfer(1, 32'h20, 1'b0, 4'hF, 32'h0, rd, term, eod, lat);
    check("r20_data", {32'd0, rd}, 64'h11BB33DD);
    check("r20_eod",  {63'd0, eod}, 64'd0);
    check("acc_5",    {48'd0, acc1}, 64'd5);

    // One past the last word: error, no data, not counted
    xfer(1, 32'h1000, 1'b0, 4'hF, 32'h0, rd, term, eod, lat);
    check("oor_term", {61'd0, term}, 64'b010);
    check("oor_rdat", {32'd0, rd}, 64'd0);
    check("oor_acc",  {48'd0, acc1}, 64'd5);

    // Low address bits ignored
    xfer(1, 32'h13, 1'b0, 4'hF, 32'h0, rd, term, eod, lat);
    check("r13_data", {32'd0, rd}, 64'hDEADBEEF);

    // Last word: eod together with ack
    xfer(1, 32'hFFC, 1'b1, 4'hF, 32'h12345678, rd, term, eod, lat);
    check("wffc_eod", {63'd0, eod}, 64'd1);
    xfer(1, 32'hFFC, 1'b0, 4'hF, 32'h0, rd, term, eod, lat);
    check("rffc_term", {61'd0, term}, 64'b100);
    check("rffc_eod",  {63'd0, eod}, 64'd1);
    check("rffc_data", {32'd0, rd}, 64'h12345678);
    check("acc_8",     {48'd0, acc1}, 64'd8);

    // Three wait states, then an aborted write
    xfer(3, 32'h30, 1'b1, 4'hF, 32'hCAFEF00D, rd, term, eod, lat);
    check("w30_lat", 64'(lat), 64'd4);
    m_dut = 3; m_adr = 32'h30; m_we = 1'b1; m_sel = 4'hF; m_wdat = 32'h55;
    m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    seen = 3'b000;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | {bus3.ack, bus3.err, bus3.rty};
    end
    check("abort_noterm", {61'd0, seen}, 64'd0);
    @(negedge clk);
    xfer(3, 32'h30, 1'b0, 4'hF, 32'h0, rd, term, eod, lat);
    check("r30_data", {32'd0, rd}, 64'hCAFEF00D);
    check("r30_lat",  64'(lat), 64'd4);
    check("acc3_2",   {48'd0, acc3}, 64'd2);

    // Eight reads on the RTY_PERIOD=4 instance
    for (int i = 0; i < 8; i++) begin
      xfer(4, 32'h40 + 32'(4*i), 1'b0, 4'hF, 32'h0, rd, term, eod, lat);
`ifdef WB_SLAVE_RTY_EN
      if ((i % 4) == 3) begin
        check($sformatf("rty_term%0d", i), {61'd0, term}, 64'b001);
        check($sformatf("rty_rdat%0d", i), {32'd0, rd}, 64'd0);
      end else begin
        check($sformatf("rty_term%0d", i), {61'd0, term}, 64'b100);
      end
`else
      check($sformatf("rty_term%0d", i), {61'd0, term}, 64'b100);
`endif
    end
`ifdef WB_SLAVE_RTY_EN
    check("accr", {48'd0, accr}, 64'd6);
`else
    check("accr", {48'd0, accr}, 64'd8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
